// File: rtl/ps2_pkg.sv
// Shared types and constants for the receive-only PS/2 mouse front end.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;
    localparam int PKT_BYTES     = 3;
    localparam int PKT_SYNC_BIT  = 3;
    localparam int STROBE_BIT    = 24;
    localparam int PKT_WIDTH     = STROBE_BIT + 1;

    localparam int BYTE0_LSB = 0;
    localparam int X_LSB     = 8;
    localparam int Y_LSB     = 16;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    // True when the data byte plus its parity bit has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a saturating glitch filter for one PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The filtered value flips only on the FILTER_LEN-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= 2'b11;
            filtered <= 1'b1;
            cnt      <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filtered) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filtered <= sync[1];
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: line conditioning, 11-bit frame deserialiser and 3-byte packet assembly.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 6000,
    parameter int PKT_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [PKT_WIDTH-1:0] ps2_mouse,
    output logic                 frame_err
);

    localparam int BT_W = $clog2(BIT_TIMEOUT + 1);
    localparam int PT_W = $clog2(PKT_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BIT_TIMEOUT - 1);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(PKT_TIMEOUT - 1);
    localparam int BC_W = $clog2(PS2_DATA_BITS);

    logic clk_filt, data_filt, clk_prev, fall;
    logic bit_timeout, pkt_expire;
    logic [1:0] idx_eff;

    frame_state_e             state;
    logic [BC_W-1:0]          bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift;
    logic                     parity_ok;
    logic [BT_W-1:0]          bit_timer;
    logic [PT_W-1:0]          pkt_timer;
    logic [1:0]               byte_idx;
    logic [PS2_DATA_BITS-1:0] byte0;
    logic [PS2_DATA_BITS-1:0] x_byte;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (ps2_clk),
        .filtered (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (ps2_data),
        .filtered (data_filt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) clk_prev <= 1'b1;
        else          clk_prev <= clk_filt;
    end

    // A fall outranks a bit timeout; an expiring packet timer makes this byte index 0.
    always_comb begin
        fall        = clk_prev & ~clk_filt;
        bit_timeout = (state != IDLE) && !fall && (bit_timer == BT_LAST);
        pkt_expire  = (byte_idx != 2'd0) && (pkt_timer == PT_LAST);
        idx_eff     = pkt_expire ? 2'd0 : byte_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            parity_ok <= 1'b0;
            bit_timer <= '0;
            pkt_timer <= '0;
            byte_idx  <= 2'd0;
            byte0     <= '0;
            x_byte    <= '0;
            ps2_mouse <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (state == IDLE || fall || bit_timeout) bit_timer <= '0;
            else                                      bit_timer <= bit_timer + 1'b1;

            if (byte_idx == 2'd0 || pkt_expire) pkt_timer <= '0;
            else                                pkt_timer <= pkt_timer + 1'b1;

            if (pkt_expire) byte_idx <= 2'd0;

            if (bit_timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift[bit_cnt] <= data_filt;
                        if (bit_cnt == BC_W'(PS2_DATA_BITS - 1)) state <= PARITY;
                        else                                     bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        parity_ok <= odd_parity_ok(shift, data_filt);
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_filt && parity_ok) begin
                            pkt_timer <= '0;
                            // Byte 0 must carry the always-one sync bit, otherwise it is dropped.
                            if (idx_eff == 2'd0) begin
                                if (shift[PKT_SYNC_BIT]) begin
                                    byte0    <= shift;
                                    byte_idx <= 2'd1;
                                end
                            end else if (idx_eff < 2'(PKT_BYTES - 1)) begin
                                x_byte   <= shift;
                                byte_idx <= idx_eff + 2'd1;
                            end else begin
                                ps2_mouse[BYTE0_LSB +: PS2_DATA_BITS] <= byte0;
                                ps2_mouse[X_LSB +: PS2_DATA_BITS]     <= x_byte;
                                ps2_mouse[Y_LSB +: PS2_DATA_BITS]     <= shift;
                                ps2_mouse[STROBE_BIT]                 <= ~ps2_mouse[STROBE_BIT];
                                byte_idx                              <= 2'd0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= 2'd0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: drives PS/2 frames and checks published packets and errors.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

    localparam int FILTER_LEN  = 8;
    localparam int BIT_TIMEOUT = 200;
    localparam int PKT_TIMEOUT = 5000;
    localparam int HALF_BIT    = 40;
    localparam int FRAME_GAP   = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [24:0] ps2_mouse;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int err_count = 0;
    int exp_errs = 0;
    logic        err_prev = 1'b0;
    logic        last_toggle = 1'b0;
    logic        exp_toggle = 1'b0;
    logic [24:0] last_pub = '0;
    logic [24:0] exp_q[$];

    ps2_mouse_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT),
        .PKT_TIMEOUT (PKT_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_mouse (ps2_mouse),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Sends the first n_bits of an 11-bit frame; glitch adds a short rejected clock pulse per bit.
    task automatic applyStimulus(input logic [7:0] value, input bit bad_parity,
                                 input bit glitch, input int n_bits);
        logic [10:0] frame;
        frame = {1'b1, (~^value) ^ bad_parity, value, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            if (glitch) begin
                repeat (4) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FILTER_LEN - 2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF_BIT / 2 - 4 - (FILTER_LEN - 2)) @(negedge clk);
            end else begin
                repeat (HALF_BIT / 2) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF_BIT) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF_BIT / 2 - 1) @(negedge clk);
        end
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        repeat (FRAME_GAP) @(negedge clk);
    endtask

    task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit glitch);
        applyStimulus(b0, 1'b0, glitch, 11);
        applyStimulus(b1, 1'b0, glitch, 11);
        exp_toggle = ~exp_toggle;
        last_pub   = {exp_toggle, b2, b1, b0};
        exp_q.push_back(last_pub);
        applyStimulus(b2, 1'b0, glitch, 11);
    endtask

    task automatic endPhase(input string tag);
        repeat (30) @(negedge clk);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_errs"}, err_count, exp_errs);
        checkOutput({tag, "_hold"}, ps2_mouse, last_pub);
    endtask

    // Monitor: error pulse width/count, and packet publication against the scoreboard.
    initial forever begin
        logic [24:0] exp;
        @(negedge clk);
        if (reset_n === 1'b1) begin
            if (frame_err === 1'b1) begin
                checkOutput("err_single_cycle", err_prev, 1'b0);
                if (!err_prev) err_count++;
            end
            err_prev = frame_err;
            if (ps2_mouse[24] !== last_toggle) begin
                last_toggle = ps2_mouse[24];
                if (exp_q.size() == 0) begin
                    checkOutput("pub_expected", 0, 1);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput("pkt", ps2_mouse, exp);
                    // 2 sync stages + FILTER_LEN filter samples + 1 publish edge
                    checkOutput("pub_latency", cyc - stop_cyc, FILTER_LEN + 3);
                end
            end
        end
    end

    initial begin
        reset_n  = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mouse", ps2_mouse, 0);
        checkOutput("reset_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] clean packet");
        sendPacket(8'h09, 8'h05, 8'hFB, 1'b0);
        endPhase("clean");
        checkOutput("clean_value", ps2_mouse, {1'b1, 24'hFB0509});

        $display("[TB] parity error");
        applyStimulus(8'h09, 1'b0, 1'b0, 11);
        applyStimulus(8'h05, 1'b1, 1'b0, 11);
        exp_errs++;
        sendPacket(8'h08, 8'h01, 8'h02, 1'b0);
        endPhase("parity");

        $display("[TB] resync");
        applyStimulus(8'h00, 1'b0, 1'b0, 11);
        sendPacket(8'h08, 8'h10, 8'h20, 1'b0);
        endPhase("resync");

        $display("[TB] glitch rejection");
        sendPacket(8'h09, 8'h05, 8'hFB, 1'b1);
        endPhase("glitch");

        $display("[TB] bit timeout");
        applyStimulus(8'h09, 1'b0, 1'b0, 11);
        applyStimulus(8'hA5, 1'b0, 1'b0, 5);
        repeat (BIT_TIMEOUT + 10) @(negedge clk);
        exp_errs++;
        sendPacket(8'h0A, 8'h11, 8'h22, 1'b0);
        endPhase("bit_timeout");

        $display("[TB] packet timeout");
        applyStimulus(8'h09, 1'b0, 1'b0, 11);
        applyStimulus(8'h05, 1'b0, 1'b0, 11);
        repeat (PKT_TIMEOUT + 10) @(negedge clk);
        endPhase("pkt_idle");
        sendPacket(8'h0C, 8'h33, 8'h44, 1'b0);
        endPhase("pkt_timeout");

        $display("[TB] reset mid-packet");
        applyStimulus(8'h09, 1'b0, 1'b0, 11);
        applyStimulus(8'h05, 1'b0, 1'b0, 11);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_mouse", ps2_mouse, 0);
        checkOutput("midreset_err", frame_err, 0);
        reset_n     = 1'b1;
        exp_toggle  = 1'b0;
        last_pub    = '0;
        last_toggle = 1'b0;
        err_prev    = 1'b0;
        repeat (5) @(negedge clk);
        sendPacket(8'h0F, 8'h7F, 8'h80, 1'b0);
        endPhase("after_reset");
        checkOutput("after_reset_value", ps2_mouse, {1'b1, 24'h807F0F});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
